// File: rtl/draw_cmd_scheduler.sv
// Round-robin scheduler sharing one draw-core command port between NREQ requesters.
// Grant is one edge after a request is sampled; a watchdog abandons commands whose done never arrives.
module draw_cmd_scheduler #(
  parameter int          NREQ        = 4,
  parameter int          CMD_W       = 4,
  parameter int          DATA_W      = 32,
  parameter int          TO_W        = 24,
  parameter int unsigned TIMEOUT_CYC = 24'hFFFFFF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [NREQ-1:0]        iReq,
  input  logic [NREQ*CMD_W-1:0]  iCmd,
  input  logic [NREQ*DATA_W-1:0] iData,
  output logic [NREQ-1:0]        oAck,
  output logic                   oTimeout,
  output logic                   oBusy,
  output logic [2:0]             oGrant_Idx,
  output logic                   oCore_En,
  output logic [CMD_W-1:0]       oCore_Cmd,
  output logic [DATA_W-1:0]      oCore_Data,
  input  logic                   iCore_Done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RELEASE
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic [2:0]          last_q, last_d;
  logic [2:0]          grant_q, grant_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic                core_en_q, core_en_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NREQ-1:0]     ack_q, ack_d;
  logic                tmo_q, tmo_d;

  logic [NREQ-1:0]     hi_mask;
  logic [NREQ-1:0]     hi_req;
  logic [2:0]          pick_hi;
  logic [2:0]          pick_any;
  logic [2:0]          pick;
  logic                any_req;
  logic [CMD_W-1:0]    cmd_sel;
  logic [DATA_W-1:0]   data_sel;

  // Requesters above the last grant win first; otherwise wrap to the lowest index.
  always_comb begin
    hi_mask  = '0;
    pick_hi  = '0;
    pick_any = '0;
    for (int k = 0; k < NREQ; k++) begin
      hi_mask[k] = (k > int'(last_q));
    end
    hi_req = iReq & hi_mask;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hi_req[k]) pick_hi = k[2:0];
      if (iReq[k])   pick_any = k[2:0];
    end
    any_req = |iReq;
    pick    = (|hi_req) ? pick_hi : pick_any;
  end

  always_comb begin
    cmd_sel  = '0;
    data_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick == k[2:0]) begin
        cmd_sel  = iCmd[k*CMD_W +: CMD_W];
        data_sel = iData[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    wd_d      = wd_q;
    core_en_d = core_en_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    ack_d     = '0;
    tmo_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && any_req) begin
          grant_d   = pick;
          last_d    = pick;
          cmd_d     = cmd_sel;
          data_d    = data_sel;
          core_en_d = 1'b1;
          wd_d      = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done takes priority over a watchdog expiry on the same cycle.
        if (iCore_Done) begin
          core_en_d = 1'b0;
          ack_d     = NREQ'(1) << grant_q;
          state_d   = S_RELEASE;
        end else if (wd_q == WD_LAST) begin
          core_en_d = 1'b0;
          tmo_d     = 1'b1;
          state_d   = S_RELEASE;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        core_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      last_q    <= 3'(NREQ - 1);
      grant_q   <= '0;
      wd_q      <= '0;
      core_en_q <= 1'b0;
      cmd_q     <= '0;
      data_q    <= '0;
      ack_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      wd_q      <= wd_d;
      core_en_q <= core_en_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      tmo_q     <= tmo_d;
    end
  end

  assign oAck       = ack_q;
  assign oTimeout   = tmo_q;
  assign oBusy      = (state_q == S_WAIT) || (state_q == S_RELEASE);
  assign oGrant_Idx = grant_q;
  assign oCore_En   = core_en_q;
  assign oCore_Cmd  = cmd_q;
  assign oCore_Data = data_q;

endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Self-checking bench for draw_cmd_scheduler with a transaction-level round-robin model.
module tb_draw_cmd_scheduler;
  localparam int NREQ   = 4;
  localparam int CMD_W  = 4;
  localparam int DATA_W = 32;
  localparam int TO_W   = 24;
  localparam int TMO    = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic [NREQ-1:0]        iReq = '0;
  logic [NREQ*CMD_W-1:0]  iCmd = '0;
  logic [NREQ*DATA_W-1:0] iData = '0;
  logic                   iCore_Done = 1'b0;
  logic [NREQ-1:0]        oAck;
  logic                   oTimeout;
  logic                   oBusy;
  logic [2:0]             oGrant_Idx;
  logic                   oCore_En;
  logic [CMD_W-1:0]       oCore_Cmd;
  logic [DATA_W-1:0]      oCore_Data;

  int n_cmp = 0;
  int n_err = 0;
  int last_m = NREQ - 1;

  draw_cmd_scheduler #(
    .NREQ(NREQ), .CMD_W(CMD_W), .DATA_W(DATA_W), .TO_W(TO_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .iReq(iReq), .iCmd(iCmd), .iData(iData),
    .oAck(oAck), .oTimeout(oTimeout), .oBusy(oBusy), .oGrant_Idx(oGrant_Idx),
    .oCore_En(oCore_En), .oCore_Cmd(oCore_Cmd), .oCore_Data(oCore_Data),
    .iCore_Done(iCore_Done)
  );

  always #5 clk = ~clk;

  // Status word: {core_en, busy, timeout, ack}
  wire [6:0] st = {oCore_En, oBusy, oTimeout, oAck};

  function automatic int exp_grant(input logic [NREQ-1:0] req, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (last + off) % NREQ;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    iReq = '0;
    iCore_Done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    last_m = NREQ - 1;
  endtask

  task automatic scramble_bus();
    for (int k = 0; k < NREQ; k++) begin
      iCmd[k*CMD_W +: CMD_W]    = CMD_W'($urandom);
      iData[k*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({st, oGrant_Idx, oCore_Cmd, oCore_Data} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got st=%b idx=%0d cmd=%h data=%h, want all zero", st, oGrant_Idx, oCore_Cmd, oCore_Data);
    end
    en = 1'b1;
    iReq = '1;
    tick();
    tick();
    n_cmp++;
    if (st !== 7'b0) begin
      n_err++;
      $display("FAIL reset_hold: got st=%b, want 0000000 while rst_n low", st);
    end
    iReq = '0;
    rst_n = 1'b1;
    last_m = NREQ - 1;
    tick();
  endtask

  task automatic test_single();
    int g;
    logic [NREQ-1:0] oh;
    scramble_bus();
    iCmd[2*CMD_W +: CMD_W]    = 4'd5;
    iData[2*DATA_W +: DATA_W] = 32'h1234;
    iReq = 4'b0100;
    en = 1'b1;
    g = exp_grant(iReq, last_m);
    tick();
    n_cmp++;
    if ({st, oGrant_Idx, oCore_Cmd, oCore_Data} !== {7'b1100000, 3'(g), 4'd5, 32'h1234}) begin
      n_err++;
      $display("FAIL t1_grant: got st=%b idx=%0d cmd=%h data=%h, want st=1100000 idx=%0d cmd=5 data=1234", st, oGrant_Idx, oCore_Cmd, oCore_Data, g);
    end
    last_m = g;
    iReq = '0;
    scramble_bus();
    repeat (9) tick();
    n_cmp++;
    if ({st, oCore_Cmd, oCore_Data} !== {7'b1100000, 4'd5, 32'h1234}) begin
      n_err++;
      $display("FAIL t1_hold: got st=%b cmd=%h data=%h, want st=1100000 cmd=5 data=1234", st, oCore_Cmd, oCore_Data);
    end
    iCore_Done = 1'b1;
    tick();
    oh = NREQ'(1) << g;
    n_cmp++;
    if (st !== {3'b010, oh}) begin
      n_err++;
      $display("FAIL t1_ack: got st=%b, want %b", st, {3'b010, oh});
    end
    iCore_Done = 1'b0;
    tick();
    n_cmp++;
    if ({st, oGrant_Idx} !== {7'b0, 3'(g)}) begin
      n_err++;
      $display("FAIL t1_idle: got st=%b idx=%0d, want st=0000000 idx=%0d", st, oGrant_Idx, g);
    end
  endtask

  task automatic test_rotation();
    apply_reset();
    en = 1'b1;
    iReq = '1;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NREQ; k++) iCmd[k*CMD_W +: CMD_W] = CMD_W'(i + 1);
      tick();
      n_cmp++;
      if ({st, oGrant_Idx, oCore_Cmd} !== {7'b1100000, 3'(i % NREQ), CMD_W'(i + 1)}) begin
        n_err++;
        $display("FAIL t2_grant%0d: got st=%b idx=%0d cmd=%h, want st=1100000 idx=%0d cmd=%h", i, st, oGrant_Idx, oCore_Cmd, i % NREQ, i + 1);
      end
      last_m = i % NREQ;
      for (int k = 0; k < NREQ; k++) iCmd[k*CMD_W +: CMD_W] = 4'hF;
      repeat ($urandom_range(0, 4)) tick();
      iCore_Done = 1'b1;
      tick();
      iCore_Done = 1'b0;
      n_cmp++;
      if ({st, oCore_Cmd} !== {3'b010, NREQ'(1) << (i % NREQ), CMD_W'(i + 1)}) begin
        n_err++;
        $display("FAIL t2_ack%0d: got st=%b cmd=%h, want ack of %0d cmd=%h", i, st, oCore_Cmd, i % NREQ, i + 1);
      end
      tick();
      n_cmp++;
      if (st !== 7'b0) begin
        n_err++;
        $display("FAIL t2_gap%0d: got st=%b, want 0000000", i, st);
      end
    end
    iReq = '0;
    tick();
  endtask

  task automatic test_watchdog();
    int g, n_en, n_to, n_ack;
    en = 1'b1;
    iReq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    g = exp_grant(iReq, last_m);
    tick();
    last_m = g;
    iReq = '0;
    n_en = oCore_En ? 1 : 0;
    n_to = 0;
    n_ack = 0;
    for (int j = 0; j < 40 && oCore_En; j++) begin
      tick();
      if (oCore_En) n_en++;
      if (oTimeout) n_to++;
      if (|oAck) n_ack++;
    end
    n_cmp++;
    if ({n_en, n_to, n_ack} !== {32'd16, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL t3_watchdog: got en_cycles=%0d timeouts=%0d acks=%0d, want 16 1 0", n_en, n_to, n_ack);
    end
    tick();
    n_cmp++;
    if (st !== 7'b0) begin
      n_err++;
      $display("FAIL t3_pulse: got st=%b, want 0000000 after timeout pulse", st);
    end
    iReq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    g = exp_grant(iReq, last_m);
    tick();
    n_cmp++;
    if ({st, oGrant_Idx} !== {7'b1100000, 3'(g)}) begin
      n_err++;
      $display("FAIL t3_next: got st=%b idx=%0d, want st=1100000 idx=%0d", st, oGrant_Idx, g);
    end
    last_m = g;
    iReq = '0;
    iCore_Done = 1'b1;
    tick();
    iCore_Done = 1'b0;
    tick();
  endtask

  task automatic test_coincidence();
    int g;
    iReq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    g = exp_grant(iReq, last_m);
    tick();
    last_m = g;
    iReq = '0;
    repeat (15) tick();
    n_cmp++;
    if (st !== 7'b1100000) begin
      n_err++;
      $display("FAIL t4_pre: got st=%b, want 1100000 at watchdog 15", st);
    end
    iCore_Done = 1'b1;
    tick();
    iCore_Done = 1'b0;
    n_cmp++;
    if (st !== {3'b010, NREQ'(1) << g}) begin
      n_err++;
      $display("FAIL t4_coincide: got st=%b, want %b", st, {3'b010, NREQ'(1) << g});
    end
    tick();
  endtask

  task automatic test_en_gating();
    int g;
    en = 1'b1;
    iReq = NREQ'(1) << $urandom_range(0, NREQ - 1);
    g = exp_grant(iReq, last_m);
    tick();
    last_m = g;
    en = 1'b0;
    iReq = 4'b0011;
    repeat (3) tick();
    iCore_Done = 1'b1;
    tick();
    iCore_Done = 1'b0;
    n_cmp++;
    if (st !== {3'b010, NREQ'(1) << g}) begin
      n_err++;
      $display("FAIL t5_ack: got st=%b, want %b", st, {3'b010, NREQ'(1) << g});
    end
    repeat (6) tick();
    n_cmp++;
    if ({st, oGrant_Idx} !== {7'b0, 3'(g)}) begin
      n_err++;
      $display("FAIL t5_gated: got st=%b idx=%0d, want st=0000000 idx=%0d", st, oGrant_Idx, g);
    end
    en = 1'b1;
    g = exp_grant(4'b0011, last_m);
    tick();
    n_cmp++;
    if ({st, oGrant_Idx} !== {7'b1100000, 3'(g)}) begin
      n_err++;
      $display("FAIL t5_resume: got st=%b idx=%0d, want st=1100000 idx=%0d", st, oGrant_Idx, g);
    end
    last_m = g;
    iReq = '0;
    iCore_Done = 1'b1;
    tick();
    iCore_Done = 1'b0;
    tick();
  endtask

  task automatic test_random_traffic();
    int g, d, bad;
    for (int i = 0; i < 25; i++) begin
      en = 1'b1;
      scramble_bus();
      iReq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      g = exp_grant(iReq, last_m);
      tick();
      n_cmp++;
      if ({st, oGrant_Idx, oCore_Cmd, oCore_Data} !== {7'b1100000, 3'(g), iCmd[g*CMD_W +: CMD_W], iData[g*DATA_W +: DATA_W]}) begin
        n_err++;
        $display("FAIL rnd_grant%0d: got st=%b idx=%0d cmd=%h data=%h, want idx=%0d cmd=%h data=%h", i, st, oGrant_Idx, oCore_Cmd, oCore_Data, g, iCmd[g*CMD_W +: CMD_W], iData[g*DATA_W +: DATA_W]);
      end
      last_m = g;
      d = $urandom_range(0, 20);
      bad = 0;
      for (int j = 0; j < ((d < TMO) ? d : TMO - 1); j++) begin
        logic [CMD_W-1:0]  c0;
        logic [DATA_W-1:0] d0;
        c0 = oCore_Cmd;
        d0 = oCore_Data;
        iReq = NREQ'($urandom);
        scramble_bus();
        tick();
        if (st !== 7'b1100000 || oCore_Cmd !== c0 || oCore_Data !== d0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
        n_err++;
        $display("FAIL rnd_hold%0d: got %0d unstable WAIT cycles, want 0", i, bad);
      end
      iCore_Done = (d < TMO);
      tick();
      n_cmp++;
      if (d < TMO && st !== {3'b010, NREQ'(1) << g}) begin
        n_err++;
        $display("FAIL rnd_ack%0d: got st=%b, want %b (delay %0d)", i, st, {3'b010, NREQ'(1) << g}, d);
      end else if (d >= TMO && st !== 7'b0110000) begin
        n_err++;
        $display("FAIL rnd_timeout%0d: got st=%b, want 0110000 (delay %0d)", i, st, d);
      end
      iCore_Done = 1'($urandom_range(0, 1));
      tick();
      iCore_Done = 1'b0;
      n_cmp++;
      if (st !== 7'b0) begin
        n_err++;
        $display("FAIL rnd_release%0d: got st=%b, want 0000000", i, st);
      end
    end
    iReq = '0;
  endtask

  task automatic test_reset_mid_wait();
    en = 1'b1;
    iReq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    tick();
    iReq = '0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({st, oGrant_Idx} !== '0) begin
      n_err++;
      $display("FAIL t6_async: got st=%b idx=%0d, want all zero right after rst_n fall", st, oGrant_Idx);
    end
    #1;
    rst_n = 1'b1;
    last_m = NREQ - 1;
    iReq = '1;
    tick();
    n_cmp++;
    if ({st, oGrant_Idx} !== {7'b1100000, 3'd0}) begin
      n_err++;
      $display("FAIL t6_first: got st=%b idx=%0d, want st=1100000 idx=0", st, oGrant_Idx);
    end
    last_m = 0;
    iReq = '0;
    iCore_Done = 1'b1;
    tick();
    iCore_Done = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_watchdog();
    test_coincidence();
    test_en_gating();
    test_random_traffic();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
